// File: rtl/debounce_en_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debounce_en_gen
// Brief    : Synchronises and debounces a raw input, producing a clean level
//            plus one-cycle rise/fall enable strobes and a busy flag.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_en_gen #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise_en,
    output logic o_fall_en,
    output logic o_busy
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_TO_HIGH = 2'd1,
        S_HIGH    = 2'd2,
        S_TO_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic                   r_level;
    logic                   w_level_nxt;
    logic                   r_rise;
    logic                   w_rise_nxt;
    logic                   r_fall;
    logic                   w_fall_nxt;

    // Stage 0 is the LSB; only the last stage is seen by the qualifier.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            S_LOW: begin
                if (w_s) begin
                    w_state_nxt = S_TO_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            S_TO_HIGH: begin
                // Any drop back to 0 discards the whole window.
                if (!w_s) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_MAX) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = S_TO_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            S_TO_LOW: begin
                if (w_s) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_MAX) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_level   = r_level;
    assign o_rise_en = r_rise;
    assign o_fall_en = r_fall;
    assign o_busy    = (r_state == S_TO_HIGH) || (r_state == S_TO_LOW);

endmodule
`default_nettype wire

// File: tb/tb_debounce_en_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_debounce_en_gen
// Brief    : Scoreboard bench for debounce_en_gen (SYNC_STAGES=2, STABLE=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_en_gen;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int CW     = 3;
    localparam int LAT    = SYNC + STABLE + 1;

    typedef struct {
        bit kind;   // 1 = rise, 0 = fall
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn = 1'b0;
    logic level, rise, fall, busy;

    int   cyc      = 0;
    int   run_n    = 0;
    int   checks   = 0;
    int   failures = 0;
    int   n_rise   = 0;
    int   n_fall   = 0;
    bit   prev_rise = 1'b0;
    bit   prev_fall = 1'b0;
    ev_t  exp_q[$];
    ev_t  e_mon;

    debounce_en_gen #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .CNT_WIDTH    (CW)
    ) u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_btn    (btn),
        .o_level  (level),
        .o_rise_en(rise),
        .o_fall_en(fall),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Each observed strobe is matched against the oldest expected event.
    always @(negedge clk) begin
        if (rise || fall) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pulse_unexpected: rise=%0b fall=%0b at cyc %0d, required no pulse", rise, fall, cyc);
            end else begin
                e_mon = exp_q.pop_front();
                if (rise !== e_mon.kind || fall !== !e_mon.kind || cyc != e_mon.cyc) begin
                    failures++;
                    $display("FAIL pulse_sb: rise=%0b fall=%0b cyc=%0d, required rise=%0b fall=%0b cyc=%0d",
                             rise, fall, cyc, e_mon.kind, !e_mon.kind, e_mon.cyc);
                end
            end
            checks++;
            if ((rise && prev_rise) || (fall && prev_fall)) begin
                failures++;
                $display("FAIL pulse_width: strobe high two cycles at cyc %0d, required one", cyc);
            end
        end
        if (rise) n_rise++;
        if (fall) n_fall++;
        prev_rise = rise;
        prev_fall = fall;
    end

    task automatic drive(input bit v);
        @(negedge clk);
        if (v !== btn) run_n = cyc;
        btn = v;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({level, rise, fall, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async: outs=%b, required 0000", {level, rise, fall, busy});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({level, rise, fall, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle: outs=%b, required 0000", {level, rise, fall, busy});
        end
    endtask

    task automatic test_press();
        int n;
        @(negedge clk);
        n   = cyc;
        btn = 1'b1;
        exp_q.push_back('{kind: 1'b1, cyc: n + LAT});
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks += 2;
            if (busy !== (k >= 3 && k <= 6)) begin
                failures++;
                $display("FAIL press_busy: k=%0d busy=%b, required %0b", k, busy, (k >= 3 && k <= 6));
            end
            if (level !== (k >= LAT)) begin
                failures++;
                $display("FAIL press_level: k=%0d level=%b, required %0b", k, level, (k >= LAT));
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL press_missing: %0d pulses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_release();
        int n;
        @(negedge clk);
        n   = cyc;
        btn = 1'b0;
        exp_q.push_back('{kind: 1'b0, cyc: n + LAT});
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks += 2;
            if (rise !== 1'b0) begin
                failures++;
                $display("FAIL release_rise: k=%0d rise=%b, required 0", k, rise);
            end
            if (level !== (k < LAT)) begin
                failures++;
                $display("FAIL release_level: k=%0d level=%b, required %0b", k, level, (k < LAT));
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL release_missing: %0d pulses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_bounce();
        int n, r0;
        r0 = n_rise;
        @(negedge clk);
        n = cyc;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (level !== (k >= 4 + LAT)) begin
                failures++;
                $display("FAIL bounce_level: k=%0d level=%b, required %0b", k, level, (k >= 4 + LAT));
            end
            btn = (k == 3) ? 1'b0 : 1'b1;
            if (k == 4) exp_q.push_back('{kind: 1'b1, cyc: n + 4 + LAT});
        end
        checks++;
        if (n_rise - r0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bounce_count: rises=%0d outstanding=%0d, required 1 and 0", n_rise - r0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n, m;
        // Level is high here; an asynchronous reset must clear it at once.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({level, rise, fall, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_high: outs=%b, required 0000", {level, rise, fall, busy});
        end
        @(negedge clk);
        btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n   = cyc;
        btn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_busy: busy=%b before abort, required 1", busy);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({level, rise, fall, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_abort: outs=%b, required 0000", {level, rise, fall, busy});
        end
        repeat (2) @(negedge clk);
        m   = cyc;
        rst = 1'b0;
        exp_q.push_back('{kind: 1'b1, cyc: m + LAT});
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (level !== (k >= LAT)) begin
                failures++;
                $display("FAIL reset_mid_level: k=%0d level=%b, required %0b (start cyc %0d)", k, level, (k >= LAT), n);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_missing: %0d pulses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        int r0, f0, changes, len, glitches, w;
        bit lvl, v, t;
        r0      = n_rise;
        f0      = n_fall;
        changes = 0;
        lvl     = btn;
        for (int b = 0; b < 1000; b++) begin
            glitches = $urandom_range(1, 4);
            v        = !lvl;
            for (int g = 0; g < glitches; g++) begin
                w = $urandom_range(1, 3);
                for (int i = 0; i < w; i++) drive(v);
                v = !v;
            end
            t   = 1'($urandom_range(0, 1));
            len = $urandom_range(6, 12);
            for (int i = 0; i < len; i++) begin
                drive(t);
                if (i == 0 && t != lvl) begin
                    exp_q.push_back('{kind: t, cyc: run_n + LAT});
                    changes++;
                    lvl = t;
                end
            end
        end
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        checks += 3;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_missing: %0d pulses outstanding, required 0", exp_q.size());
        end
        if ((n_rise - r0) + (n_fall - f0) != changes) begin
            failures++;
            $display("FAIL random_count: pulses=%0d, required %0d", (n_rise - r0) + (n_fall - f0), changes);
        end
        if (level !== lvl) begin
            failures++;
            $display("FAIL random_level: level=%b, required %0b", level, lvl);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_en_gen.md
Name: debounce_en_gen

Overview:
- Conditions a raw, asynchronous, bouncing input (push-button or switch) into clean synchronous signals for the enable-flip-flop register stage downstream.
- o_level feeds the downstream data input.
- o_rise_en and o_fall_en are single-cycle strobes that feed the downstream enable input.
- The block contains a synchroniser, a stability counter and a 4-state FSM.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on i_btn (legal: 2..4)
STABLE_CYCLES, 1000000, consecutive clock cycles the synchronised input must hold before a level change is accepted (legal: >= 2)
CNT_WIDTH, 20, stability counter width; must satisfy 2**CNT_WIDTH >= STABLE_CYCLES

Ports:
i_clk  input  1  system clock; all state updates on its rising edge
i_rst  input  1  reset; asynchronous, active-high
i_btn  input  1  raw asynchronous input, may bounce
o_level  output  1  debounced level of i_btn
o_rise_en  output  1  one-cycle pulse when o_level goes 0->1
o_fall_en  output  1  one-cycle pulse when o_level goes 1->0
o_busy  output  1  high while a candidate transition is being qualified

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values while i_rst is high, taking effect immediately:
  - all synchroniser flops 0, state S_LOW, counter 0
  - o_level 0, o_rise_en 0, o_fall_en 0, o_busy 0
- Synchroniser: SYNC_STAGES-deep flop chain on i_btn. Its last stage is s. Only s is used downstream of the chain.
- States: S_LOW, S_TO_HIGH, S_HIGH, S_TO_LOW. o_busy = (state is S_TO_HIGH or S_TO_LOW), decoded from registered state.
- S_LOW:
  - s=1 -> S_TO_HIGH, counter <= 0.
  - s=0 -> stay.
- S_TO_HIGH:
  - s=0 -> S_LOW, counter <= 0, no pulse (bounce rejected).
  - s=1 and counter /= STABLE_CYCLES-1 -> counter++.
  - s=1 and counter = STABLE_CYCLES-1 -> S_HIGH, o_level <= 1, o_rise_en <= 1 for exactly one cycle.
- S_HIGH:
  - s=0 -> S_TO_LOW, counter <= 0.
  - s=1 -> stay.
- S_TO_LOW: mirror of S_TO_HIGH with s polarity inverted. On qualification: -> S_LOW, o_level <= 0, o_fall_en <= 1 for one cycle.
- Latency:
  - Edge 1 is the first rising edge at which sync stage 0 captures the new value, and i_btn stays stable from then on.
  - o_level and the matching pulse are high after edge SYNC_STAGES + STABLE_CYCLES + 1.
  - The pulse is high during the first cycle of the new o_level value.
- Pulses are registered outputs.
  - o_rise_en and o_fall_en are never high simultaneously.
  - Neither pulse is ever high for two consecutive cycles.
- Counter:
  - Never exceeds STABLE_CYCLES-1 and never wraps.
  - Cleared on every entry to a qualifying state and on every bounce.
- Any single-cycle glitch on s during qualification restarts the full STABLE_CYCLES window. There is no partial credit.
- Reset asserted mid-qualification aborts with no pulse and returns to S_LOW.
- Reset released while i_btn is held high:
  - the block qualifies normally from S_LOW
  - o_rise_en pulses once after the full latency.
- Glitches shorter than a clock period may be missed entirely; this is acceptable.
- No combinational path from i_btn to any output.

Test Plan:
- Reset check (SYNC_STAGES=2, STABLE_CYCLES=4): assert i_rst mid-cycle -> all outputs 0 immediately, before the next edge.
- Clean press, same parameters: i_btn 0->1 captured at edge 1 and held -> o_level=1 and o_rise_en=1 after edge 7; o_rise_en=0 after edge 8; o_busy high after edges 3..6 only.
- Bounce rejection: i_btn high for 3 cycles, low 1 cycle, then held high -> o_level stays 0 until a full 4-cycle stable window completes; exactly one o_rise_en pulse.
- Clean release from S_HIGH: i_btn 1->0 held -> o_level=0 and o_fall_en=1 for one cycle, 7 edges after capture; o_rise_en stays 0 throughout.
- Reset mid-operation: assert i_rst while in S_TO_HIGH with counter=2 -> no pulse, state S_LOW. Release reset with i_btn still high -> a single o_rise_en after 7 edges.
- Randomised bouncing: 1000 bursts of random glitch widths 1..3 cycles between stable periods of >= 6 cycles. Required:
  - rise and fall pulse counts equal the number of stable level changes
  - pulses strictly alternate rise/fall
  - no two-cycle pulses.
